// File: rtl/step_ramp_scheduler_pkg.sv
// Shared types, the half-step phase table and the phase stepping helper
// for the stepper ramp scheduler.
package stepper_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STEP   = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } state_e;

  // Coil patterns indexed by half-step phase; even entries are single-coil,
  // odd entries are the two-coil intermediate positions.
  localparam logic [3:0] PHASE_TBL [8] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

  // Advance the table index by one (half-step) or two (full-step) entries,
  // backwards when dir is set; the 3-bit result wraps mod 8 naturally.
  function automatic logic [2:0] phase_next(input logic [2:0] idx,
                                            input logic       dir,
                                            input logic       half);
    logic [2:0] stride;
    stride = half ? 3'd1 : 3'd2;
    return dir ? (idx - stride) : (idx + stride);
  endfunction

endpackage

// File: rtl/step_ramp_scheduler_if.sv
// Move-command handshake between the control FSM and the scheduler.
interface step_ramp_scheduler_if #(
  parameter int STEP_W = 16
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic signed [STEP_W-1:0] cmd_steps;
  logic                     cmd_half;

  modport master (output cmd_valid, output cmd_steps, output cmd_half, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_steps, input cmd_half, output cmd_ready);
endinterface

// File: rtl/step_ramp_scheduler_timer.sv
// Down-counting step delay timer: load a value, count to zero and hold.
module step_delay_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] value_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] value_q;

  // Load has priority; otherwise count down and stop at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value_q <= '0;
    end else if (load_i) begin
      value_q <= load_val_i;
    end else if (value_q != '0) begin
      value_q <= value_q - CNT_W'(1);
    end
  end

  assign value_o = value_q;
  assign zero_o  = (value_q == '0);

endmodule

// File: rtl/step_ramp_scheduler.sv
// Trapezoidal-rate stepper phase sequencer: accepts a signed relative move,
// walks the half-step phase table and ramps the step period down and back up.
module step_ramp_scheduler
  import stepper_pkg::*;
#(
  parameter int STEP_W    = 16,
  parameter int CNT_W     = 20,
  parameter int MAX_DELAY = 50000,
  parameter int MIN_DELAY = 10000,
  parameter int RAMP_DEC  = 2000
) (
  input  logic                clk,
  input  logic                reset_n,
  step_ramp_scheduler_if.slave cmd,
  input  logic                abort,
  output logic [3:0]          coil,
  output logic [2:0]          phase_idx,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [STEP_W-1:0]   steps_left
);

  localparam logic [CNT_W-1:0] MAX_D = CNT_W'(MAX_DELAY);
  localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DELAY);

  // Speed-down step (longer period), clamped at the start/stop period.
  function automatic logic [CNT_W-1:0] sat_up(input logic [CNT_W-1:0] d);
    logic [CNT_W:0] s;
    s = {1'b0, d} + (CNT_W+1)'(RAMP_DEC);
    return (s > {1'b0, MAX_D}) ? MAX_D : s[CNT_W-1:0];
  endfunction

  // Speed-up step (shorter period), clamped at the cruise period; the extra
  // bit catches borrow when RAMP_DEC exceeds the current period.
  function automatic logic [CNT_W-1:0] sat_dn(input logic [CNT_W-1:0] d);
    logic [CNT_W:0] s;
    s = {1'b0, d} - (CNT_W+1)'(RAMP_DEC);
    return (s[CNT_W] || (s < {1'b0, MIN_D})) ? MIN_D : s[CNT_W-1:0];
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] accel_q, accel_d;
  logic [CNT_W-1:0]  cur_delay_q, cur_delay_d;
  logic              dir_q, dir_d;
  logic              half_q, half_d;
  logic              aborted_q, aborted_d;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic [CNT_W-1:0]  tmr_value;
  logic              tmr_zero;
  logic [STEP_W-1:0] cmd_mag;
  logic [STEP_W-1:0] remaining;

  // Magnitude as unsigned, so the most negative count maps to 2**(STEP_W-1).
  assign cmd_mag   = cmd.cmd_steps[STEP_W-1] ? (~cmd.cmd_steps + STEP_W'(1)) : cmd.cmd_steps;
  assign remaining = steps_q - STEP_W'(1);

  step_delay_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .value_o   (tmr_value),
    .zero_o    (tmr_zero)
  );

  // State and move-context registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= 3'd0;
      steps_q     <= '0;
      accel_q     <= '0;
      cur_delay_q <= MAX_D;
      dir_q       <= 1'b0;
      half_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      steps_q     <= steps_d;
      accel_q     <= accel_d;
      cur_delay_q <= cur_delay_d;
      dir_q       <= dir_d;
      half_q      <= half_d;
      aborted_q   <= aborted_d;
    end
  end

  // Next-state, phase advance and ramp update.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    steps_d     = steps_q;
    accel_d     = accel_q;
    cur_delay_d = cur_delay_q;
    dir_d       = dir_q;
    half_d      = half_q;
    aborted_d   = aborted_q;
    tmr_load    = 1'b0;
    // The WAIT count is two short so STEP plus WAIT spans exactly cur_delay.
    tmr_val     = cur_delay_q - CNT_W'(2);
    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          state_d     = LOAD;
          dir_d       = cmd.cmd_steps[STEP_W-1];
          half_d      = cmd.cmd_half;
          steps_d     = cmd_mag;
          cur_delay_d = MAX_D;
          accel_d     = '0;
          aborted_d   = 1'b0;
        end
      end
      LOAD: state_d = (steps_q == '0) ? FINISH : STEP;
      STEP: begin
        phase_d  = phase_next(phase_q, dir_q, half_q);
        steps_d  = remaining;
        tmr_load = 1'b1;
        // Decelerate once the steps left fit within the steps spent speeding up.
        if (remaining <= accel_q) begin
          cur_delay_d = sat_up(cur_delay_q);
        end else if (cur_delay_q > MIN_D) begin
          cur_delay_d = sat_dn(cur_delay_q);
          accel_d     = accel_q + STEP_W'(1);
        end
        if (abort) begin
          state_d   = FINISH;
          aborted_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d   = FINISH;
          aborted_d = 1'b1;
        end else if (tmr_zero) begin
          state_d = (steps_q != '0) ? STEP : FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cmd.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FINISH);
  assign aborted       = aborted_q;
  assign phase_idx     = phase_q;
  assign coil          = PHASE_TBL[phase_q];
  assign steps_left    = steps_q;

endmodule

// File: tb/tb_step_ramp_scheduler.sv
// Directed bench for step_ramp_scheduler with a short ramp (10/4/2).
module tb_step_ramp_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        abort;
  logic [3:0]  coil;
  logic [2:0]  phase_idx;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] steps_left;
  int          tests = 0;
  int          fails = 0;

  step_ramp_scheduler_if #(.STEP_W(16)) cif ();

  step_ramp_scheduler #(
    .STEP_W(16), .CNT_W(20), .MAX_DELAY(10), .MIN_DELAY(4), .RAMP_DEC(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd       (cif),
    .abort     (abort),
    .coil      (coil),
    .phase_idx (phase_idx),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly its accept edge.
  task automatic start_move(input int steps, input logic half);
    cif.cmd_valid = 1'b1;
    cif.cmd_steps = 16'(steps);
    cif.cmd_half  = half;
    tick();
    cif.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tests++; if (phase_idx !== 3'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", phase_idx); end
    tests++; if (coil !== 4'b1000) begin fails++; $display("FAIL reset_coil: got %b want 1000", coil); end
    tests++; if (cif.cmd_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL reset_ready_busy: got %b%b want 10", cif.cmd_ready, busy); end
    tests++; if (done !== 1'b0 || aborted !== 1'b0) begin fails++; $display("FAIL reset_done_aborted: got %b%b want 00", done, aborted); end
    tests++; if (steps_left !== 16'd0) begin fails++; $display("FAIL reset_steps_left: got %0d want 0", steps_left); end
  endtask

  task automatic test_full_ramp();
    logic [2:0] idx_exp [5] = '{3'd2, 3'd4, 3'd6, 3'd0, 3'd2};
    int         gap_exp [4] = '{10, 8, 6, 8};
    logic [2:0] seen [8];
    int         t [8];
    int         nchg = 0;
    int         dones = 0;
    bit         fin = 0;
    logic [2:0] prev;
    start_move(5, 1'b0);
    prev = phase_idx;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (done) dones++;
      if (phase_idx !== prev) begin
        if (nchg < 8) begin seen[nchg] = phase_idx; t[nchg] = c; end
        nchg++;
        prev = phase_idx;
      end
      if (dones > 0 && !done) begin fin = 1; break; end
    end
    tests++; if (!fin) begin fails++; $display("FAIL full_timeout: got no done want done"); end
    tests++; if (nchg != 5) begin fails++; $display("FAIL full_nchg: got %0d want 5", nchg); end
    for (int i = 0; i < 5 && i < nchg; i++) begin
      tests++; if (seen[i] !== idx_exp[i]) begin fails++; $display("FAIL full_idx%0d: got %0d want %0d", i, seen[i], idx_exp[i]); end
    end
    for (int i = 0; i < 4 && i + 1 < nchg; i++) begin
      tests++; if (t[i+1] - t[i] != gap_exp[i]) begin fails++; $display("FAIL full_gap%0d: got %0d want %0d", i, t[i+1] - t[i], gap_exp[i]); end
    end
    tests++; if (dones != 1) begin fails++; $display("FAIL full_done_pulses: got %0d want 1", dones); end
    tests++; if (busy !== 1'b0 || steps_left !== 16'd0) begin fails++; $display("FAIL full_end: got busy=%b left=%0d want 0 0", busy, steps_left); end
  endtask

  task automatic test_half_reverse();
    logic [2:0]  idx_exp  [3] = '{3'd7, 3'd6, 3'd5};
    logic [3:0]  coil_exp [3] = '{4'b1001, 4'b0001, 4'b0011};
    logic [15:0] left_exp [3] = '{16'd2, 16'd1, 16'd0};
    int          nchg = 0;
    bit          fin = 0;
    logic [2:0]  prev;
    // Start from a known phase.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    start_move(-3, 1'b1);
    prev = phase_idx;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (phase_idx !== prev) begin
        if (nchg < 3) begin
          tests++; if (phase_idx !== idx_exp[nchg]) begin fails++; $display("FAIL half_idx%0d: got %0d want %0d", nchg, phase_idx, idx_exp[nchg]); end
          tests++; if (coil !== coil_exp[nchg]) begin fails++; $display("FAIL half_coil%0d: got %b want %b", nchg, coil, coil_exp[nchg]); end
          tests++; if (steps_left !== left_exp[nchg]) begin fails++; $display("FAIL half_left%0d: got %0d want %0d", nchg, steps_left, left_exp[nchg]); end
        end
        nchg++;
        prev = phase_idx;
      end
      if (done) begin fin = 1; break; end
    end
    tests++; if (!fin || nchg != 3) begin fails++; $display("FAIL half_end: got fin=%0d changes=%0d want 1 3", fin, nchg); end
    tick();
  endtask

  task automatic test_zero_steps();
    logic [2:0] idx0;
    idx0 = phase_idx;
    start_move(0, 1'b0);
    tests++; if (done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL zero_load: got done=%b busy=%b want 0 1", done, busy); end
    tick();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done: got %b want 1", done); end
    tick();
    tests++; if (done !== 1'b0 || cif.cmd_ready !== 1'b1) begin fails++; $display("FAIL zero_idle: got done=%b ready=%b want 0 1", done, cif.cmd_ready); end
    tests++; if (phase_idx !== idx0) begin fails++; $display("FAIL zero_idx: got %0d want %0d", phase_idx, idx0); end
  endtask

  task automatic test_abort();
    int         nchg = 0;
    logic [2:0] prev;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    start_move(20, 1'b0);
    prev = phase_idx;
    for (int c = 0; c < 300 && nchg < 3; c++) begin
      tick();
      if (phase_idx !== prev) begin nchg++; prev = phase_idx; end
    end
    tests++; if (nchg != 3) begin fails++; $display("FAIL abort_reach: got %0d changes want 3", nchg); end
    // First cycle of the third WAIT.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++; if (done !== 1'b1 || aborted !== 1'b1) begin fails++; $display("FAIL abort_done: got done=%b aborted=%b want 1 1", done, aborted); end
    tests++; if (phase_idx !== 3'd6) begin fails++; $display("FAIL abort_idx: got %0d want 6", phase_idx); end
    tests++; if (steps_left !== 16'd17) begin fails++; $display("FAIL abort_left: got %0d want 17", steps_left); end
    tick();
    tests++; if (busy !== 1'b0 || aborted !== 1'b1 || phase_idx !== 3'd6) begin fails++; $display("FAIL abort_idle: got busy=%b aborted=%b idx=%0d want 0 1 6", busy, aborted, phase_idx); end
  endtask

  task automatic test_back_to_back();
    int  ready_bad = 0;
    bit  fin = 0;
    // Phase is 6 from the aborted move: +2 full then +2 full ends at 6 again.
    cif.cmd_valid = 1'b1;
    cif.cmd_steps = 16'sd2;
    cif.cmd_half  = 1'b0;
    tick();
    tests++; if (aborted !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: got aborted=%b busy=%b want 0 1", aborted, busy); end
    for (int c = 0; c < 300; c++) begin
      if (cif.cmd_ready !== 1'b0) ready_bad++;
      if (done) begin fin = 1; break; end
      tick();
    end
    tests++; if (!fin || ready_bad != 0) begin fails++; $display("FAIL b2b_ready_low: got fin=%0d ready_high=%0d want 1 0", fin, ready_bad); end
    tests++; if (phase_idx !== 3'd2) begin fails++; $display("FAIL b2b_idx1: got %0d want 2", phase_idx); end
    tick();
    tests++; if (cif.cmd_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL b2b_gap: got ready=%b busy=%b want 1 0", cif.cmd_ready, busy); end
    tick();
    cif.cmd_valid = 1'b0;
    tests++; if (busy !== 1'b1 || cif.cmd_ready !== 1'b0) begin fails++; $display("FAIL b2b_second: got busy=%b ready=%b want 1 0", busy, cif.cmd_ready); end
    fin = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (done) begin fin = 1; break; end
    end
    tests++; if (!fin || phase_idx !== 3'd6) begin fails++; $display("FAIL b2b_idx2: got fin=%0d idx=%0d want 1 6", fin, phase_idx); end
    tick();
  endtask

  task automatic test_reset_mid_move();
    logic [2:0] prev;
    bit         moved = 0;
    start_move(8, 1'b0);
    prev = phase_idx;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (phase_idx !== prev) begin moved = 1; break; end
    end
    tests++; if (!moved || busy !== 1'b1) begin fails++; $display("FAIL rst_mid_setup: got moved=%0d busy=%b want 1 1", moved, busy); end
    tick();
    reset_n = 1'b0;
    tick();
    tests++; if (phase_idx !== 3'd0 || coil !== 4'b1000) begin fails++; $display("FAIL rst_mid_phase: got idx=%0d coil=%b want 0 1000", phase_idx, coil); end
    tests++; if (cif.cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rst_mid_ctrl: got ready=%b busy=%b done=%b want 1 0 0", cif.cmd_ready, busy, done); end
    tests++; if (steps_left !== 16'd0) begin fails++; $display("FAIL rst_mid_left: got %0d want 0", steps_left); end
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n       = 1'b0;
    abort         = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_steps = '0;
    cif.cmd_half  = 1'b0;
    test_reset();
    test_full_ramp();
    test_half_reverse();
    test_zero_steps();
    test_abort();
    test_back_to_back();
    test_reset_mid_move();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
